frame_update_scheduler: RTL and testbench
=========================================

Name: frame_update_scheduler

Overview:
- Sequences per-frame game-state updates so that all object engines (paddles, ball, score) change their state only during vertical blanking, never while pixels are being drawn.
- On each entry into vertical blanking it grants an update slot to each client in turn, in fixed order, using a req/done handshake.
- Sits beside the VGA timing generator and consumes its registered line counter.
- Flags a sticky overrun if a sequence is still running when blanking ends.

Parameters:
- N_CLIENTS, 4, number of update clients; client 0 is served first. Legal range 2..8.
- Y_POS_W, 10, width of the line-counter input.
- SCREEN_V_RES, 480, first non-visible line; vertical blanking is pixel_y_i >= SCREEN_V_RES.
- FRAME_CNT_W, 8, width of the completed-frame counter.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- pixel_y_i  in  Y_POS_W  current line from the VGA timing generator
- enable_i  in  1  allows new sequences to start
- upd_done_i  in  N_CLIENTS  per-client completion; sampled only for the client currently requested
- overrun_clr_i  in  1  clears overrun_o
- upd_req_o  out  N_CLIENTS  one-hot update request, or all zero
- cur_client_o  out  $clog2(N_CLIENTS)  index of the client being served
- busy_o  out  1  a sequence is in progress
- frame_tick_o  out  1  one-cycle pulse at each vblank entry
- frame_cnt_o  out  FRAME_CNT_W  count of fully completed sequences
- overrun_o  out  1  sticky: blanking ended before the sequence completed

Behaviour:
- All outputs are registered.
- Reset values: upd_req_o=0, cur_client_o=0, busy_o=0, frame_tick_o=0, frame_cnt_o=0, overrun_o=0, FSM=IDLE.
- Internal vb_q resets to 1, so no spurious start occurs if reset releases mid-blank.
- vb_now = (pixel_y_i >= SCREEN_V_RES).
- vb_q <= vb_now every cycle.
- vb_rise = vb_now & ~vb_q.
- frame_tick_o <= vb_rise, regardless of enable_i or FSM state.
- FSM states: IDLE, REQ.
- IDLE, on vb_rise & enable_i: go to REQ with idx=0.
  - Next cycle: upd_req_o=1<<0, cur_client_o=0, busy_o=1.
  - Latency from vb_rise cycle to first request: 1 cycle.
- IDLE, on vb_rise & ~enable_i: stay in IDLE; that frame is skipped and frame_cnt_o is unchanged.
- REQ: upd_req_o[idx] is held high until upd_done_i[idx]=1 is sampled. upd_done_i bits for other clients are ignored.
  - Done sampled and idx<N_CLIENTS-1: next cycle idx+1, request moves to the next client with no gap cycle.
  - Done sampled and idx=N_CLIENTS-1: next cycle go to IDLE, upd_req_o=0, busy_o=0, frame_cnt_o+1 (wraps modulo 2^FRAME_CNT_W), cur_client_o returns to 0.
  - Done is permitted in the same cycle the request first rises; this gives 1 cycle per client minimum.
- Abort: in REQ with vb_now=0 (blanking ended), and not the case of done for the last client in that same cycle:
  - next cycle overrun_o=1, go to IDLE, upd_req_o=0, busy_o=0;
  - frame_cnt_o is not incremented.
  - Done for the last client in the same cycle as blanking ends counts as completion, with no overrun.
- overrun_o stays set until overrun_clr_i=1. Set has priority over clear in the same cycle.
- enable_i falling during REQ does not abort; the sequence runs to completion or to abort.
- rst_i asserted mid-sequence: upd_req_o=0 and busy_o=0 on the next cycle; no completion is counted.
- Clients must treat req as level. Deassertion without a done means the slot was revoked.

Test Plan:
- Reset, then pixel_y_i steps 479->480 at cycle t, enable_i=1, each client returns done 2 cycles after its req:
  - frame_tick_o pulses at t+1; upd_req_o=0001 at t+1;
  - the request walks 0010, 0100, 1000 at 3-cycle spacing;
  - busy_o falls and frame_cnt_o=1 immediately after client 3's done.
- Client 1 holds done low, and pixel_y_i wraps 524->0:
  - the cycle after the wrap, upd_req_o=0, busy_o=0, overrun_o=1, frame_cnt_o unchanged;
  - overrun_clr_i pulse then gives overrun_o=0;
  - overrun_clr_i asserted in the same cycle as a new abort leaves overrun_o=1.
- Client 3's done lands in the same cycle pixel_y_i wraps to 0 -> frame_cnt_o increments, overrun_o stays 0.
- enable_i=0 at vblank entry -> frame_tick_o still pulses, upd_req_o stays 0, frame_cnt_o unchanged.
- Reset released with pixel_y_i=500 -> no tick and no request until the next 479->480 transition.
- Done asserted for a non-current client (upd_done_i=0100 while upd_req_o=0001) -> ignored, request stays 0001.
- 256 completed frames with FRAME_CNT_W=8 -> frame_cnt_o wraps to 0.
- rst_i asserted while upd_req_o=0100 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/frame_update_scheduler.sv
// Hands out one update slot per client, in fixed order, at each entry into
// vertical blanking so game-state engines never change while pixels are drawn.
module frame_update_scheduler #(
    parameter int N_CLIENTS    = 4,
    parameter int Y_POS_W      = 10,
    parameter int SCREEN_V_RES = 480,
    parameter int FRAME_CNT_W  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [Y_POS_W-1:0]           pixel_y_i,
    input  logic                         enable_i,
    input  logic [N_CLIENTS-1:0]         upd_done_i,
    input  logic                         overrun_clr_i,
    output logic [N_CLIENTS-1:0]         upd_req_o,
    output logic [$clog2(N_CLIENTS)-1:0] cur_client_o,
    output logic                         busy_o,
    output logic                         frame_tick_o,
    output logic [FRAME_CNT_W-1:0]       frame_cnt_o,
    output logic                         overrun_o
);

    localparam int CLI_W = $clog2(N_CLIENTS);
    localparam logic [CLI_W-1:0]   LAST_IDX = CLI_W'(N_CLIENTS - 1);
    localparam logic [Y_POS_W-1:0] V_RES    = Y_POS_W'(SCREEN_V_RES);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                   state_reg;
    logic                     vb_reg;
    logic [N_CLIENTS-1:0]     upd_req_reg;
    logic [CLI_W-1:0]         idx_reg;
    logic                     busy_reg;
    logic                     frame_tick_reg;
    logic [FRAME_CNT_W-1:0]   frame_cnt_reg;
    logic                     overrun_reg;

    logic                     vb_now;
    logic                     vb_rise;
    logic [N_CLIENTS-1:0]     done_hit;
    logic                     done_cur;
    logic                     last_client;
    logic                     seq_complete;
    logic                     seq_abort;

    assign vb_now  = (pixel_y_i >= V_RES);
    assign vb_rise = vb_now & ~vb_reg;

    // The request vector is one-hot, so masking by it picks out the served client's done.
    genvar gi;
    generate
        for (gi = 0; gi < N_CLIENTS; gi++) begin : g_done
            assign done_hit[gi] = upd_req_reg[gi] & upd_done_i[gi];
        end
    endgenerate

    assign done_cur     = |done_hit;
    assign last_client  = (idx_reg == LAST_IDX);
    assign seq_complete = (state_reg == REQ) && done_cur && last_client;
    assign seq_abort    = (state_reg == REQ) && !vb_now && !seq_complete;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            vb_reg         <= 1'b1;  // avoids a false start when reset releases mid-blank
            upd_req_reg    <= '0;
            idx_reg        <= '0;
            busy_reg       <= 1'b0;
            frame_tick_reg <= 1'b0;
            frame_cnt_reg  <= '0;
            overrun_reg    <= 1'b0;
        end else begin
            vb_reg         <= vb_now;
            frame_tick_reg <= vb_rise;

            if (seq_abort) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (vb_rise && enable_i) begin
                        state_reg   <= REQ;
                        idx_reg     <= '0;
                        upd_req_reg <= N_CLIENTS'(1);
                        busy_reg    <= 1'b1;
                    end
                end
                REQ: begin
                    if (seq_complete) begin
                        state_reg     <= IDLE;
                        idx_reg       <= '0;
                        upd_req_reg   <= '0;
                        busy_reg      <= 1'b0;
                        frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
                    end else if (seq_abort) begin
                        state_reg   <= IDLE;
                        idx_reg     <= '0;
                        upd_req_reg <= '0;
                        busy_reg    <= 1'b0;
                    end else if (done_cur) begin
                        idx_reg     <= idx_reg + CLI_W'(1);
                        upd_req_reg <= upd_req_reg << 1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    upd_req_reg <= '0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign upd_req_o    = upd_req_reg;
    assign cur_client_o = idx_reg;
    assign busy_o       = busy_reg;
    assign frame_tick_o = frame_tick_reg;
    assign frame_cnt_o  = frame_cnt_reg;
    assign overrun_o    = overrun_reg;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench: stimulus pushes hand-derived expected outputs tagged with the
// cycle they must appear in; a monitor pops and compares on the falling edge.
module tb_frame_update_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [9:0] pixel_y_i;
    logic       enable_i;
    logic [3:0] upd_done_i;
    logic       overrun_clr_i;
    logic [3:0] upd_req_o;
    logic [1:0] cur_client_o;
    logic       busy_o;
    logic       frame_tick_o;
    logic [7:0] frame_cnt_o;
    logic       overrun_o;

    always #5 clk_i = ~clk_i;

    frame_update_scheduler #(
        .N_CLIENTS(4), .Y_POS_W(10), .SCREEN_V_RES(480), .FRAME_CNT_W(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pixel_y_i(pixel_y_i), .enable_i(enable_i),
        .upd_done_i(upd_done_i), .overrun_clr_i(overrun_clr_i),
        .upd_req_o(upd_req_o), .cur_client_o(cur_client_o), .busy_o(busy_o),
        .frame_tick_o(frame_tick_o), .frame_cnt_o(frame_cnt_o), .overrun_o(overrun_o)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] req;
        logic [1:0] cli;
        logic       busy;
        logic       tick;
        logic [7:0] cnt;
        logic       ovr;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic       exp_ovr = 1'b0;
    bit         stim_done = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Outputs registered by the next rising edge.
    task automatic expect_out(input string name, input logic [3:0] req, input logic [1:0] cli,
                              input logic busy, input logic tk);
        exp_t e;
        e.cyc = cyc + 1; e.name = name; e.req = req; e.cli = cli;
        e.busy = busy; e.tick = tk; e.cnt = exp_cnt; e.ovr = exp_ovr;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycle(input string name);
        expect_out(name, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic start_frame();
        pixel_y_i = 10'd480;
        expect_out("vb_entry", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick();
    endtask

    // Entered with client k's request already visible; done rises after 'delay' cycles.
    task automatic serve(input int k, input int delay);
        for (int d = 0; d < delay; d++) begin
            expect_out("hold", 4'(1 << k), 2'(k), 1'b1, 1'b0);
            tick();
        end
        upd_done_i = 4'(1 << k);
        if (k < 3) begin
            expect_out("advance", 4'(1 << (k + 1)), 2'(k + 1), 1'b1, 1'b0);
        end else begin
            exp_cnt = exp_cnt + 8'd1;
            expect_out("complete", 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        tick();
        upd_done_i = 4'b0000;
    endtask

    task automatic leave_blank();
        pixel_y_i = 10'd0;
        idle_cycle("active");
    endtask

    initial begin : monitor
        exp_t e;
        bit   drained;
        drained = 1'b0;
        forever begin
            @(negedge clk_i);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || upd_req_o !== e.req || cur_client_o !== e.cli ||
                    busy_o !== e.busy || frame_tick_o !== e.tick ||
                    frame_cnt_o !== e.cnt || overrun_o !== e.ovr) begin
                    errors++;
                    $display("FAIL %s @%0d (due %0d): got req=%b cli=%0d busy=%b tick=%b cnt=%0d ovr=%b, expected req=%b cli=%0d busy=%b tick=%b cnt=%0d ovr=%b",
                             e.name, cyc, e.cyc, upd_req_o, cur_client_o, busy_o, frame_tick_o,
                             frame_cnt_o, overrun_o, e.req, e.cli, e.busy, e.tick, e.cnt, e.ovr);
                end else begin
                    $display("ok   %s @%0d req=%b cli=%0d busy=%b tick=%b cnt=%0d ovr=%b",
                             e.name, cyc, upd_req_o, cur_client_o, busy_o, frame_tick_o,
                             frame_cnt_o, overrun_o);
                end
            end
            if (stim_done && !drained) begin
                drained = 1'b1;
                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded 20000 cycles, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_i = 1'b1; pixel_y_i = 10'd500; enable_i = 1'b1;
        upd_done_i = 4'b0000; overrun_clr_i = 1'b0;

        // Reset while mid-blank, then release: no tick until a real 479->480 edge.
        idle_cycle("reset");
        idle_cycle("reset_hold");
        rst_i = 1'b0;
        repeat (3) idle_cycle("midblank_release");
        pixel_y_i = 10'd520;
        idle_cycle("midblank_520");
        pixel_y_i = 10'd479;
        idle_cycle("pre_vb");

        // Normal frame, each done two cycles after its request.
        start_frame();
        for (int k = 0; k < 4; k++) serve(k, 2);
        leave_blank();

        // Done from a client other than the one being served is ignored.
        start_frame();
        upd_done_i = 4'b0100;
        expect_out("foreign_done", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("foreign_done", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        upd_done_i = 4'b0000;
        serve(0, 1); serve(1, 0); serve(2, 0); serve(3, 1);
        leave_blank();

        // Client 1 stalls past the end of blanking.
        start_frame();
        serve(0, 2);
        expect_out("client1_wait", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        pixel_y_i = 10'd0;
        exp_ovr = 1'b1;
        expect_out("abort", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        idle_cycle("ovr_sticky");
        overrun_clr_i = 1'b1;
        exp_ovr = 1'b0;
        expect_out("ovr_clear", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        overrun_clr_i = 1'b0;
        idle_cycle("ovr_cleared");

        // Abort and clear in the same cycle: set wins.
        start_frame();
        serve(0, 0);
        pixel_y_i = 10'd0;
        overrun_clr_i = 1'b1;
        exp_ovr = 1'b1;
        expect_out("abort_vs_clr", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        overrun_clr_i = 1'b0;
        idle_cycle("ovr_kept");
        overrun_clr_i = 1'b1;
        exp_ovr = 1'b0;
        expect_out("ovr_clear2", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        overrun_clr_i = 1'b0;

        // Enable drops mid-sequence; last done coincides with blanking end.
        start_frame();
        serve(0, 1);
        enable_i = 1'b0;
        serve(1, 1); serve(2, 1);
        upd_done_i = 4'b1000;
        pixel_y_i = 10'd0;
        exp_cnt = exp_cnt + 8'd1;
        expect_out("last_done_at_wrap", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        upd_done_i = 4'b0000;
        enable_i = 1'b1;
        idle_cycle("after_wrap_done");

        // Disabled at vblank entry: tick only.
        enable_i = 1'b0;
        pixel_y_i = 10'd480;
        expect_out("vb_disabled", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        repeat (2) idle_cycle("vb_disabled_idle");
        pixel_y_i = 10'd0;
        enable_i = 1'b1;
        idle_cycle("active");

        // Reset while client 2 is being served.
        start_frame();
        serve(0, 1); serve(1, 1);
        rst_i = 1'b1;
        exp_cnt = 8'd0;
        exp_ovr = 1'b0;
        expect_out("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        rst_i = 1'b0;
        idle_cycle("post_rst");
        pixel_y_i = 10'd0;
        idle_cycle("active");

        // 256 minimum-length frames wrap the 8-bit counter back to 0.
        for (int f = 0; f < 256; f++) begin
            start_frame();
            for (int k = 0; k < 4; k++) serve(k, 0);
            leave_blank();
        end
        idle_cycle("cnt_wrapped");

        stim_done = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
